// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode and FSM state types for the sequential ALU.
//   ALU_OP_W    : opcode width
//   alu_op_e    : 4-bit opcode encoding
//   alu_state_e : IDLE / BUSY / DONE control states
//   is_shift_op : true for the iterative shift/rotate opcodes
//   is_mul_op   : true for MUL / MULH
package alu_pkg;

   localparam int ALU_OP_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_AND    = 4'd2,
      OP_ADC    = 4'd3,
      OP_OR     = 4'd4,
      OP_XOR    = 4'd5,
      OP_NOT    = 4'd6,
      OP_SBC    = 4'd7,
      OP_SHL    = 4'd8,
      OP_SHR    = 4'd9,
      OP_ASR    = 4'd10,
      OP_ROL    = 4'd11,
      OP_ROR    = 4'd12,
      OP_MUL    = 4'd13,
      OP_MULH   = 4'd14,
      OP_PASS_B = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   function automatic logic is_shift_op(input alu_op_e op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR) ||
             (op == OP_ROL) || (op == OP_ROR);
   endfunction

   function automatic logic is_mul_op(input alu_op_e op);
      return (op == OP_MUL) || (op == OP_MULH);
   endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: one-bit-per-cycle datapath for shifts, rotates and the
// shift-add multiplier, with its own step counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : load operands and perform the first step this cycle
//   flush_i    : abandon the running operation
//   op_i, a_i, b_i, steps_i : operation, operands and total step count
//   last_o     : the step being performed this cycle is the final one
//   res_o, carry_o, ovf_o   : result/C/V after this cycle's step
// The first step is taken on the start cycle itself so an s-step operation
// completes s cycles after acceptance; outputs are combinational views of
// the step in progress so the caller can capture them on the last step.
module alu_iter_unit
   import alu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              flush_i,
   input  alu_op_e           op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [CNT_W-1:0]  steps_i,
   output logic              last_o,
   output logic [DATA_W-1:0] res_o,
   output logic              carry_o,
   output logic              ovf_o
);

   alu_op_e           op_q;
   logic [DATA_W-1:0] a_q, hi_q, lo_q;
   logic [CNT_W-1:0]  cnt_q;

   alu_op_e           src_op;
   logic [DATA_W-1:0] src_a, src_hi, src_lo;
   logic [DATA_W-1:0] a_d, hi_d, lo_d;
   logic              c_d;
   logic [DATA_W:0]   mul_sum;

   // Step source: fresh operands on the start cycle, registered state after.
   always_comb begin
      src_op = start_i ? op_i : op_q;
      src_a  = start_i ? a_i  : a_q;
      src_hi = start_i ? '0   : hi_q;
      src_lo = start_i ? b_i  : lo_q;
      a_d    = src_a;
      hi_d   = src_hi;
      lo_d   = src_lo;
      c_d    = 1'b0;
      // Multiplier: a holds the multiplicand, lo the remaining multiplier
      // bits; the partial product shifts right out of hi into lo.
      mul_sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_a} : '0);
      case (src_op)
         OP_SHL: begin
            a_d = {src_a[DATA_W-2:0], 1'b0};
            c_d = src_a[DATA_W-1];
         end
         OP_SHR: begin
            a_d = {1'b0, src_a[DATA_W-1:1]};
            c_d = src_a[0];
         end
         OP_ASR: begin
            a_d = {src_a[DATA_W-1], src_a[DATA_W-1:1]};
            c_d = src_a[0];
         end
         OP_ROL: begin
            a_d = {src_a[DATA_W-2:0], src_a[DATA_W-1]};
            c_d = src_a[DATA_W-1];
         end
         OP_ROR: begin
            a_d = {src_a[0], src_a[DATA_W-1:1]};
            c_d = src_a[0];
         end
         OP_MUL, OP_MULH: begin
            hi_d = mul_sum[DATA_W:1];
            lo_d = {mul_sum[0], src_lo[DATA_W-1:1]};
         end
         default: ;
      endcase
   end

   always_comb begin
      res_o   = a_d;
      carry_o = c_d;
      ovf_o   = 1'b0;
      if (src_op == OP_MUL) begin
         res_o = lo_d;
         ovf_o = (hi_d != '0);
      end else if (src_op == OP_MULH) begin
         res_o = hi_d;
         ovf_o = (hi_d != '0);
      end
      last_o = start_i ? (steps_i == CNT_W'(1)) : (cnt_q == CNT_W'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= OP_ADD;
         a_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         cnt_q <= '0;
      end else if (start_i) begin
         op_q  <= op_i;
         a_q   <= a_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= steps_i - CNT_W'(1);
      end else if (cnt_q != '0) begin
         a_q   <= a_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/tristate_driver.sv
// tristate_driver: drives a shared bus from a register when enabled.
//   en_i   : drive enable
//   data_i : value to drive
//   bus_o  : tri-state bus, high impedance when en_i is low
module tristate_driver #(
   parameter int W = 8
) (
   input  logic         en_i,
   input  logic [W-1:0] data_i,
   output tri   [W-1:0] bus_o
);

   assign bus_o = en_i ? data_i : {W{1'bz}};

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with registered flags behind a request/response
// handshake; the result register drives a shared bus through a tristate.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : request handshake; alu_op, operand_a, operand_b
//                       are sampled on acceptance
//   flush             : synchronous abort of BUSY/DONE, flags kept
//   rsp_valid/ready   : response handshake; result/flags held while valid
//   output_enable     : drive alu_result from the result register
//   alu_result        : tri-state result bus
//   zero_flag, positive_flag, carry_flag, signed_overflow : registered flags
//   dbg_state_o       : current control state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on the same-side valid, and a response stays
// valid with stable data until rsp_ready is seen (or flush/reset).
module alu_seq
   import alu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int MUL_EN = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ALU_OP_W-1:0] alu_op,
   input  logic [DATA_W-1:0]   operand_a,
   input  logic [DATA_W-1:0]   operand_b,
   input  logic                flush,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   input  logic                output_enable,
   output tri   [DATA_W-1:0]   alu_result,
   output logic                zero_flag,
   output logic                positive_flag,
   output logic                carry_flag,
   output logic                signed_overflow,
   output alu_state_e          dbg_state_o
);

   localparam int SHAMT_W = $clog2(DATA_W);
   localparam int CNT_W   = SHAMT_W + 1;
   localparam int MSB     = DATA_W - 1;

   alu_state_e        state_q;
   logic [DATA_W-1:0] result_q;
   logic              zero_q, pos_q, carry_q, ovf_q, rsp_valid_q;

   alu_op_e           op;
   logic [SHAMT_W-1:0] shamt;
   logic              accept;

   logic [DATA_W-1:0] b_eff;
   logic              cin;
   logic [DATA_W:0]   add_sum;
   logic [DATA_W-1:0] sc_res;
   logic              sc_c, sc_v;
   logic              use_iter;
   logic [CNT_W-1:0]  iter_steps;

   logic              iter_start, iter_last, iter_c, iter_v;
   logic [DATA_W-1:0] iter_res;

   logic              from_iter, do_commit;
   logic [DATA_W-1:0] commit_res;
   logic              commit_c, commit_v;

   assign op    = alu_op_e'(alu_op);
   assign shamt = operand_b[SHAMT_W-1:0];

   // A request presented together with flush is never taken.
   assign req_ready = ~flush & ((state_q == IDLE) | ((state_q == DONE) & rsp_ready));
   assign accept    = req_valid & req_ready;

   // Single-cycle ops, and the decision whether the iterative unit is needed.
   always_comb begin
      b_eff      = operand_b;
      cin        = 1'b0;
      add_sum    = '0;
      sc_res     = '0;
      sc_c       = 1'b0;
      sc_v       = 1'b0;
      use_iter   = 1'b0;
      iter_steps = '0;
      case (op)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            if ((op == OP_SUB) || (op == OP_SBC)) b_eff = ~operand_b;
            if (op == OP_SUB)      cin = 1'b1;
            else if (op == OP_ADD) cin = 1'b0;
            else                   cin = carry_q;
            add_sum = {1'b0, operand_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
            sc_res  = add_sum[MSB:0];
            sc_c    = add_sum[DATA_W];
            // Overflow when both addends share a sign the result lacks.
            sc_v    = (operand_a[MSB] == b_eff[MSB]) & (sc_res[MSB] != operand_a[MSB]);
         end
         OP_AND:    sc_res = operand_a & operand_b;
         OP_OR:     sc_res = operand_a | operand_b;
         OP_XOR:    sc_res = operand_a ^ operand_b;
         OP_NOT:    sc_res = ~operand_a;
         OP_PASS_B: sc_res = operand_b;
         OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR: begin
            if (shamt == '0) begin
               sc_res = operand_a;
            end else begin
               use_iter   = 1'b1;
               iter_steps = {1'b0, shamt};
            end
         end
         OP_MUL, OP_MULH: begin
            if (MUL_EN != 0) begin
               use_iter   = 1'b1;
               iter_steps = CNT_W'(DATA_W);
            end
         end
         default: ;
      endcase
   end

   assign iter_start = accept & use_iter;

   alu_iter_unit #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_iter (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (iter_start),
      .flush_i (flush),
      .op_i    (op),
      .a_i     (operand_a),
      .b_i     (operand_b),
      .steps_i (iter_steps),
      .last_o  (iter_last),
      .res_o   (iter_res),
      .carry_o (iter_c),
      .ovf_o   (iter_v)
   );

   // Result/flags are written only on the cycle the FSM enters DONE.
   always_comb begin
      from_iter  = (state_q == BUSY) | use_iter;
      commit_res = from_iter ? iter_res : sc_res;
      commit_c   = from_iter ? iter_c   : sc_c;
      commit_v   = from_iter ? iter_v   : sc_v;
      do_commit  = (accept & (~use_iter | iter_last)) |
                   ((state_q == BUSY) & ~flush & iter_last);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rsp_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         pos_q       <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q     <= do_commit ? DONE : BUSY;
                  rsp_valid_q <= do_commit;
               end
            end
            BUSY: begin
               if (flush) begin
                  state_q <= IDLE;
               end else if (iter_last) begin
                  state_q     <= DONE;
                  rsp_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (flush) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
               end else if (accept) begin
                  state_q     <= do_commit ? DONE : BUSY;
                  rsp_valid_q <= do_commit;
               end else if (rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
            end
         endcase
         if (do_commit) begin
            result_q <= commit_res;
            zero_q   <= (commit_res == '0);
            pos_q    <= ~commit_res[MSB];
            carry_q  <= commit_c;
            ovf_q    <= commit_v;
         end
      end
   end

   assign rsp_valid       = rsp_valid_q;
   assign zero_flag       = zero_q;
   assign positive_flag   = pos_q;
   assign carry_flag      = carry_q;
   assign signed_overflow = ovf_q;
   assign dbg_state_o     = state_q;

   tristate_driver #(
      .W (DATA_W)
   ) u_bus (
      .en_i   (output_enable),
      .data_i (result_q),
      .bus_o  (alu_result)
   );

endmodule
